// File: rtl/sbmips_stack.sv
// Operand stack for the SBMIPS multicycle controller: push/pop/tos with registered read data
// and sticky overflow/underflow flags. One command completes per cycle.
module sbmips_stack #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             tos_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             err_clr_i,
   output logic [WIDTH-1:0] dout_o,
   output logic [AW:0]      count_o,
   output logic             empty_o,
   output logic             full_o,
   output logic             overflow_o,
   output logic             underflow_o
);

   localparam logic [AW:0]   DepthCnt = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CntOne   = (AW+1)'(1);
   localparam logic [AW-1:0] IdxOne   = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic             we;
   logic [AW-1:0]    waddr;
   logic [AW-1:0]    top_idx;
   logic             is_empty, is_full;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == DepthCnt);
   // Wraps to DEPTH-1 when count == DEPTH, which is the correct top slot.
   assign top_idx  = count_q[AW-1:0] - IdxOne;

   always_comb begin
      count_d = count_q;
      dout_d  = dout_q;
      ovf_d   = err_clr_i ? 1'b0 : ovf_q;
      unf_d   = err_clr_i ? 1'b0 : unf_q;
      we      = 1'b0;
      waddr   = count_q[AW-1:0];

      if (pop_i || tos_i) begin
         if (is_empty) begin
            unf_d = 1'b1;
         end else begin
            dout_d = mem_q[top_idx];
         end
      end

      if (push_i) begin
         if (pop_i && !is_empty) begin
            // Replace top in place; count and full are irrelevant.
            we    = 1'b1;
            waddr = top_idx;
         end else if (is_full) begin
            ovf_d = 1'b1;
         end else begin
            we      = 1'b1;
            count_d = count_q + CntOne;
         end
      end else if (pop_i && !is_empty) begin
         count_d = count_q - CntOne;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         dout_q  <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         dout_q  <= dout_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Storage is intentionally not reset; reset only blocks a same-cycle write.
   always_ff @(posedge clk_i) begin
      if (!rst_i && we) begin
         mem_q[waddr] <= din_i;
      end
   end

   assign dout_o      = dout_q;
   assign count_o     = count_q;
   assign empty_o     = is_empty;
   assign full_o      = is_full;
   assign overflow_o  = ovf_q;
   assign underflow_o = unf_q;

endmodule

// File: tb/tb_sbmips_stack.sv
// Bench for sbmips_stack: directed scenarios plus randomized commands checked against
// a queue-based model of the stack.
module tb_sbmips_stack;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;

   logic             clk = 1'b0;
   logic             rst, push, pop, tos, err_clr;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic [AW:0]      count;
   logic             empty, full, overflow, underflow;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   // Reference model state.
   logic [WIDTH-1:0] m_q[$];
   logic [WIDTH-1:0] m_dout;
   logic             m_ovf, m_unf;

   always #5 clk = ~clk;

   sbmips_stack #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH),
      .AW   (AW)
   ) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .push_i     (push),
      .pop_i      (pop),
      .tos_i      (tos),
      .din_i      (din),
      .err_clr_i  (err_clr),
      .dout_o     (dout),
      .count_o    (count),
      .empty_o    (empty),
      .full_o     (full),
      .overflow_o (overflow),
      .underflow_o(underflow)
   );

   task automatic check(input string tag, input int unsigned got, input int unsigned exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step(input logic r, input logic p, input logic po, input logic t,
                             input logic [WIDTH-1:0] d, input logic c);
      int unsigned n;
      if (r) begin
         m_q.delete();
         m_dout = '0;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
         return;
      end
      n = m_q.size();
      if (c) begin
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end
      if (po || t) begin
         if (n == 0) m_unf = 1'b1;
         else        m_dout = m_q[n-1];
      end
      if (p) begin
         if (po && n > 0)     m_q[n-1] = d;
         else if (n == DEPTH) m_ovf = 1'b1;
         else                 m_q.push_back(d);
      end else if (po && n > 0) begin
         void'(m_q.pop_back());
      end
   endtask

   // Apply one command for one clock, then compare every output with the model.
   task automatic step(input logic r, input logic p, input logic po, input logic t,
                       input logic [WIDTH-1:0] d, input logic c);
      rst = r; push = p; pop = po; tos = t; din = d; err_clr = c;
      @(posedge clk);
      model_step(r, p, po, t, d, c);
      #1;
      check("count", 32'(count), m_q.size());
      check("dout", 32'(dout), 32'(m_dout));
      check("empty", 32'(empty), 32'(m_q.size() == 0));
      check("full", 32'(full), 32'(m_q.size() == DEPTH));
      check("overflow", 32'(overflow), 32'(m_ovf));
      check("underflow", 32'(underflow), 32'(m_unf));
      @(negedge clk);
   endtask

   task automatic do_push(input logic [WIDTH-1:0] d);
      step(1'b0, 1'b1, 1'b0, 1'b0, d, 1'b0);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; tos = 1'b0; din = '0; err_clr = 1'b0;
      m_dout = '0; m_ovf = 1'b0; m_unf = 1'b0;
      @(negedge clk);

      // 1: push three, pop one
      do_reset();
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_dout", 32'(dout), 32'd0);
      do_push(8'h11); do_push(8'h22); do_push(8'h33);
      check("t1_count", 32'(count), 32'd3);
      step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      check("t1_pop_dout", 32'(dout), 32'h33);
      check("t1_pop_count", 32'(count), 32'd2);

      // 2: tos twice, then idle holds dout
      step(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
      check("t2_tos1", 32'(dout), 32'h22);
      step(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
      check("t2_tos2", 32'(dout), 32'h22);
      check("t2_count", 32'(count), 32'd2);
      step(1'b0, 1'b0, 1'b0, 1'b0, 8'hEE, 1'b0);
      check("t2_hold", 32'(dout), 32'h22);

      // 3: fill, overflow, clear
      do_reset();
      for (int i = 0; i < DEPTH; i++) do_push(8'(i + 1));
      check("t3_full", 32'(full), 32'd1);
      do_push(8'hAA);
      check("t3_ovf", 32'(overflow), 32'd1);
      check("t3_count", 32'(count), 32'd16);
      step(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
      check("t3_top", 32'(dout), 32'h10);
      step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b1);
      check("t3_clr", 32'(overflow), 32'd0);

      // 4: underflow, push+pop on empty
      do_reset();
      step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      check("t4_unf", 32'(underflow), 32'd1);
      check("t4_dout", 32'(dout), 32'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h5C, 1'b0);
      check("t4_count", 32'(count), 32'd1);
      step(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
      check("t4_tos", 32'(dout), 32'h5C);

      // 5: replace top
      do_reset();
      do_push(8'h01); do_push(8'h02);
      step(1'b0, 1'b1, 1'b1, 1'b0, 8'h09, 1'b0);
      check("t5_dout", 32'(dout), 32'h02);
      check("t5_count", 32'(count), 32'd2);
      step(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0);
      check("t5_pop", 32'(dout), 32'h09);

      // 6: reset wins over a same-cycle push
      do_reset();
      for (int i = 0; i < 5; i++) do_push(8'(8'h40 + i));
      step(1'b0, 1'b0, 1'b0, 1'b1, '0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h77, 1'b0);
      check("t6_count", 32'(count), 32'd0);
      check("t6_dout", 32'(dout), 32'd0);
      check("t6_empty", 32'(empty), 32'd1);

      // Randomized traffic, alternating push-heavy and pop-heavy phases.
      for (int i = 0; i < 800; i++) begin
         bit heavy;
         logic r, p, po, t, c;
         heavy = ((i / 100) % 2) == 0;
         r  = ($urandom_range(0, 199) == 0);
         p  = ($urandom_range(0, 99) < (heavy ? 70 : 30));
         po = ($urandom_range(0, 99) < (heavy ? 15 : 45));
         t  = ($urandom_range(0, 99) < 20);
         c  = ($urandom_range(0, 15) == 0);
         step(r, p, po, t, 8'($urandom), c);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
